// File: rtl/csi2_lane_deskew.sv
// Multi-lane deskew buffer between the D-PHY byte aligners and the CSI-2 packet layer.
// Each lane fills its own FIFO; a word is released only when every lane holds a byte.
module csi2_lane_deskew #(
    parameter int unsigned LANES    = 4,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_SKEW = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [LANES-1:0]     lane_valid_i,
    input  logic [8*LANES-1:0]   lane_byte_i,
    input  logic                 reset_align_i,
    output logic                 valid_o,
    output logic [8*LANES-1:0]   data_o,
    output logic                 deskew_err_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_ALL,
        S_STREAM,
        S_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   cnt_q, cnt_d, cnt_inc_c;
    logic [PW-1:0]   wr_ptr_q [LANES];
    logic [PW-1:0]   rd_ptr_q [LANES];
    logic [7:0]      mem_q    [LANES][DEPTH];

    logic [LANES-1:0] empty_c, full_c, wr_try_c, wr_en_c;
    logic             all_ne_c, all_empty_c, pop_c, ovf_c;

    // Per-lane full/empty from the registered pointers; the MSB is the wrap bit.
    always_comb begin
        for (int n = 0; n < LANES; n++) begin
            empty_c[n] = (wr_ptr_q[n] == rd_ptr_q[n]);
            full_c[n]  = (wr_ptr_q[n][AW] != rd_ptr_q[n][AW]) &&
                         (wr_ptr_q[n][AW-1:0] == rd_ptr_q[n][AW-1:0]);
        end
    end

    assign all_ne_c    = ~|empty_c;
    assign all_empty_c = &empty_c;
    assign pop_c       = all_ne_c && !reset_align_i &&
                         ((state_q == S_WAIT_ALL) || (state_q == S_STREAM));
    assign wr_try_c    = lane_valid_i & {LANES{(state_q != S_ERROR) && !reset_align_i}};
    // A full lane that pops on this edge can still accept its byte.
    assign ovf_c       = (|(wr_try_c & full_c)) && !pop_c;
    assign wr_en_c     = pop_c ? wr_try_c : (wr_try_c & ~full_c);
    assign cnt_inc_c   = (&cnt_q) ? cnt_q : cnt_q + PW'(1);

    // Next-state and skew counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (reset_align_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (ovf_c) begin
            state_d = S_ERROR;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|lane_valid_i) begin
                        state_d = S_WAIT_ALL;
                        cnt_d   = '0;
                    end
                end
                S_WAIT_ALL: begin
                    if (all_ne_c) begin
                        state_d = S_STREAM;
                        cnt_d   = '0;
                    end else if (cnt_q >= PW'(MAX_SKEW)) begin
                        state_d = S_ERROR;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
                S_STREAM: begin
                    if (all_ne_c) begin
                        cnt_d = '0;
                    end else if (all_empty_c && !(|lane_valid_i)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q >= PW'(MAX_SKEW)) begin
                        state_d = S_ERROR;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
                S_ERROR: state_d = S_ERROR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            valid_o      <= 1'b0;
            data_o       <= '0;
            deskew_err_o <= 1'b0;
            for (int n = 0; n < LANES; n++) begin
                wr_ptr_q[n] <= '0;
                rd_ptr_q[n] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            valid_o      <= pop_c;
            deskew_err_o <= (state_d == S_ERROR);
            for (int n = 0; n < LANES; n++) begin
                if (pop_c) begin
                    data_o[8*n +: 8] <= mem_q[n][rd_ptr_q[n][AW-1:0]];
                end
                if (reset_align_i) begin
                    wr_ptr_q[n] <= '0;
                    rd_ptr_q[n] <= '0;
                end else begin
                    if (wr_en_c[n]) wr_ptr_q[n] <= wr_ptr_q[n] + PW'(1);
                    if (pop_c)      rd_ptr_q[n] <= rd_ptr_q[n] + PW'(1);
                end
            end
        end
    end

    // FIFO storage needs no reset; only the pointers define occupancy.
    always_ff @(posedge clk_i) begin
        for (int n = 0; n < LANES; n++) begin
            if (wr_en_c[n]) begin
                mem_q[n][wr_ptr_q[n][AW-1:0]] <= lane_byte_i[8*n +: 8];
            end
        end
    end

endmodule
